// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk down to a pixel enable and produces
// pixel coordinates, video_on, hsync/vsync and a once-per-frame tick, all registered.
module vga_sync_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 4,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);

    // Sync windows indexed by axis: 0 = horizontal, 1 = vertical.
    localparam logic [9:0] SYNC_START [2] = '{10'(H_DISPLAY + H_FRONT),
                                              10'(V_DISPLAY + V_FRONT)};
    localparam logic [9:0] SYNC_END   [2] = '{10'(H_DISPLAY + H_FRONT + H_SYNC - 1),
                                              10'(V_DISPLAY + V_FRONT + V_SYNC - 1)};

    logic [DIV_W-1:0] div_reg, div_next;
    logic [9:0]       h_reg, h_next;
    logic [9:0]       v_reg, v_next;
    logic             p_tick_reg, p_tick_next;
    logic             video_on_reg, video_on_next;
    logic             hsync_reg, vsync_reg;
    logic             frame_tick_reg, frame_tick_next;
    logic [9:0]       axis_next [2];
    logic [1:0]       sync_next;

    // Counters move on the edge that ends a p_tick cycle, so the first pixel
    // after reset lasts a full CLK_DIV period even when CLK_DIV == 1.
    always_comb begin
        div_next    = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        p_tick_next = (div_next == DIV_LAST);
        h_next      = h_reg;
        v_next      = v_reg;
        if (p_tick_reg) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
        video_on_next   = (h_next < H_VIS) && (v_next < V_VIS);
        frame_tick_next = p_tick_next && (h_next == H_LAST) && (v_next == V_LAST);
    end

    assign axis_next[0] = h_next;
    assign axis_next[1] = v_next;

    // Decoded from next-state counters so the syncs line up with pixel_x/pixel_y.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            assign sync_next[gi] = ((axis_next[gi] >= SYNC_START[gi]) &&
                                    (axis_next[gi] <= SYNC_END[gi])) ? SYNC_POL : ~SYNC_POL;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg        <= '0;
            h_reg          <= '0;
            v_reg          <= '0;
            p_tick_reg     <= 1'b0;
            video_on_reg   <= 1'b0;
            hsync_reg      <= ~SYNC_POL;
            vsync_reg      <= ~SYNC_POL;
            frame_tick_reg <= 1'b0;
        end else begin
            div_reg        <= div_next;
            h_reg          <= h_next;
            v_reg          <= v_next;
            p_tick_reg     <= p_tick_next;
            video_on_reg   <= video_on_next;
            hsync_reg      <= sync_next[0];
            vsync_reg      <= sync_next[1];
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign p_tick     = p_tick_reg;
    assign pixel_x    = h_reg;
    assign pixel_y    = v_reg;
    assign video_on   = video_on_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, fast (CLK_DIV=1, SYNC_POL=1) and reduced-size
// instances, checked against an arithmetic model of elapsed clocks since reset.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic rst_def = 1'b1, rst_fast = 1'b1, rst_sm = 1'b1;
    logic fast_done = 1'b0, sm_done = 1'b0;

    logic       d_pt, d_von, d_hs, d_vs, d_ft;
    logic [9:0] d_x, d_y;
    logic       f_pt, f_von, f_hs, f_vs, f_ft;
    logic [9:0] f_x, f_y;
    logic       s_pt, s_von, s_hs, s_vs, s_ft;
    logic [9:0] s_x, s_y;

    vga_sync_gen u_def (
        .clk(clk), .rst(rst_def), .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_tick(d_ft)
    );

    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_fast (
        .clk(clk), .rst(rst_fast), .p_tick(f_pt), .pixel_x(f_x), .pixel_y(f_y),
        .video_on(f_von), .hsync(f_hs), .vsync(f_vs), .frame_tick(f_ft)
    );

    vga_sync_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) u_sm (
        .clk(clk), .rst(rst_sm), .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
    );

    logic [24:0] d_vec, f_vec, s_vec;
    assign d_vec = {d_pt, d_x, d_y, d_von, d_hs, d_vs, d_ft};
    assign f_vec = {f_pt, f_x, f_y, f_von, f_hs, f_vs, f_ft};
    assign s_vec = {s_pt, s_x, s_y, s_von, s_hs, s_vs, s_ft};

    // Reference: c = clk edges since the last edge that sampled reset high.
    // Pixel enables fall on every D-th cycle; the counters have advanced once
    // per completed enable, so the pixel index is plain division.
    function automatic logic [24:0] model(int c, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, int vb, int d, logic pol);
        int ht, vt, n, p, x, y;
        logic pt, von, hsy, vsy, ft;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        if (c == 0) return {1'b0, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0};
        pt  = ((c % d) == d - 1);
        n   = (d == 1) ? c - 1 : c / d;
        p   = n % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        von = (x < hd) && (y < vd);
        hsy = (x >= hd + hf && x < hd + hf + hs) ? pol : ~pol;
        vsy = (y >= vd + vf && y < vd + vf + vs) ? pol : ~pol;
        ft  = pt && (x == ht - 1) && (y == vt - 1);
        return {pt, 10'(x), 10'(y), von, hsy, vsy, ft};
    endfunction

    task automatic check_vec(string name, logic [24:0] act, logic [24:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got pt=%b x=%0d y=%0d von=%b hs=%b vs=%b ft=%b expected pt=%b x=%0d y=%0d von=%b hs=%b vs=%b ft=%b",
                     name, $time, act[24], act[23:14], act[13:4], act[3], act[2], act[1], act[0],
                     exp[24], exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle-by-cycle model comparison for each instance.
    int c_def = 0, c_fast = 0, c_sm = 0;
    logic st_def = 1'b0, st_fast = 1'b0, st_sm = 1'b0;
    logic rs_def, rs_fast, rs_sm;

    always @(posedge clk) begin
        rs_def = rst_def; rs_fast = rst_fast; rs_sm = rst_sm;
        #1;
        if (rs_def) begin c_def = 0; st_def = 1'b1; end else c_def++;
        if (rs_fast) begin c_fast = 0; st_fast = 1'b1; end else c_fast++;
        if (rs_sm) begin c_sm = 0; st_sm = 1'b1; end else c_sm++;
        if (st_def)
            check_vec("model_def", d_vec, model(c_def, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0));
        if (st_fast)
            check_vec("model_fast", f_vec, model(c_fast, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1));
        if (st_sm)
            check_vec("model_small", s_vec, model(c_sm, 4, 1, 2, 1, 3, 1, 1, 1, 2, 1'b0));
    end

    typedef struct {
        int         c;
        logic [9:0] x, y;
        logic       von, hs, vs, pt, ft;
    } vec_t;

    localparam logic [24:0] DEF_RST = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Default instance: fixed vectors, then a mid-line reset.
    initial begin
        vec_t tbl [16];
        int   cur;
        tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{4,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{7,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{2556, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2560, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{2620, 10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{2624, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{3004, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{3008, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{3196, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{3199, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{3200, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4400, 10'd300, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_def = 1'b0;
        cur = 0;
        for (int i = 0; i < 16; i++) begin
            repeat (tbl[i].c - cur) @(posedge clk);
            #1;
            cur = tbl[i].c;
            check_vec($sformatf("tbl%0d_c%0d", i, tbl[i].c), d_vec,
                      {tbl[i].pt, tbl[i].x, tbl[i].y, tbl[i].von, tbl[i].hs, tbl[i].vs, tbl[i].ft});
        end

        @(negedge clk);
        rst_def = 1'b1;
        @(posedge clk); #1;
        check_vec("def_midline_reset", d_vec, DEF_RST);
        @(negedge clk);
        rst_def = 1'b0;
        @(posedge clk); #1;
        check_vec("def_restart_c1", d_vec, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        repeat (2) @(posedge clk); #1;
        check_vec("def_restart_c3", d_vec, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});

        for (int k = 0; k < 30000 && !(fast_done && sm_done); k++) @(posedge clk);
        check_int("workers_done", int'(fast_done && sm_done), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Fast instance: occasional random resets, otherwise free-running.
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_fast = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            @(negedge clk);
            rst_fast = ($urandom_range(0, 2999) == 0);
        end
        @(negedge clk);
        rst_fast = 1'b0;
        fast_done = 1'b1;
    end

    // Small instance: frame spacing, a mid-frame reset, then random resets.
    initial begin
        time t_ft [4];
        int  k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_sm = 1'b0;

        for (int f = 0; f < 4; f++) begin
            k = 0;
            do begin @(posedge clk); #1; k++; end while (!s_ft && k < 300);
            check_int($sformatf("small_ft_found%0d", f), int'(s_ft), 1);
            t_ft[f] = $time;
        end
        for (int f = 1; f < 4; f++)
            check_int($sformatf("small_ft_spacing%0d", f), int'(t_ft[f] - t_ft[f-1]), 960);

        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(s_x == 10'd3 && s_y == 10'd2) && k < 300);
        check_int("small_reach_3_2", int'(s_x == 10'd3 && s_y == 10'd2), 1);
        @(negedge clk);
        rst_sm = 1'b1;
        @(posedge clk); #1;
        check_vec("small_midframe_reset", s_vec, DEF_RST);
        @(negedge clk);
        rst_sm = 1'b0;
        @(posedge clk); #1;
        check_vec("small_restart_c1", s_vec, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});

        for (int j = 0; j < 6000; j++) begin
            @(negedge clk);
            rst_sm = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst_sm = 1'b0;
        sm_done = 1'b1;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator directly upstream of the pixel-generation stage; produces `pixel_x`, `pixel_y`, `video_on` and the monitor sync pulses that the pixel generator consumes.
- Derives a pixel-rate enable from the system clock; default is 100 MHz / 4 = 25 MHz, giving 640x480@60 Hz.
- Also emits `p_tick` and a once-per-frame `frame_tick`, so downstream logic can update object positions only during vertical blanking.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; must be >= 1
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- p_tick  output  1  one-clk pixel enable, every CLK_DIV clocks
- pixel_x  output  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  output  10  vertical counter, 0..V_TOTAL-1
- video_on  output  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- hsync  output  1  horizontal sync, level set by SYNC_POL
- vsync  output  1  vertical sync, level set by SYNC_POL
- frame_tick  output  1  one-clk pulse on the last pixel tick of each frame

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Derived constants:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800 by default).
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (525 by default).
  - Both totals must be <= 1024.
- Reset (rst high at a clk edge), all outputs registered:
  - div counter = 0, h_cnt = 0, v_cnt = 0.
  - p_tick = 0, frame_tick = 0, video_on = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
  - Reset mid-frame aborts immediately, with no completion of the current line.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick is high for exactly the clk cycle in which div_cnt == CLK_DIV-1.
  - First p_tick occurs in the CLK_DIV-th cycle after rst deasserts.
  - If CLK_DIV == 1, p_tick is constantly 1 outside reset.
- Counters advance only in a p_tick cycle (the edge ending that cycle):
  - h_cnt == H_TOTAL-1: h_cnt -> 0 and v_cnt advances.
  - Otherwise h_cnt increments.
  - When v_cnt advances: if v_cnt == V_TOTAL-1 then v_cnt -> 0, else v_cnt increments.
  - No other event moves the counters.
- Output alignment:
  - pixel_x = h_cnt and pixel_y = v_cnt (register outputs, no extra latency).
  - video_on, hsync and vsync are registered from the next-state counters. They therefore describe the same pixel as pixel_x/pixel_y in every cycle, with zero relative skew.
  - First clk edge after reset release: video_on = 1 with pixel_x = pixel_y = 0.
- hsync is active while H_DISPLAY+H_FRONT <= h_cnt <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751 by default).
- vsync is active while V_DISPLAY+V_FRONT <= v_cnt <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491 by default).
- frame_tick:
  - High for one clk, coincident with p_tick, when h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1, i.e. the counters wrap to (0,0) at the end of that cycle.
  - Never high during reset.
- Frame length: H_TOTAL*V_TOTAL*CLK_DIV clocks (1,680,000 by default).
- Outputs are glitch-free: all flops, no combinational paths from counters to ports.

Test Plan:
- Reset then release, count clks → p_tick first high in the 4th cycle after release, then period exactly 4; video_on = 1 at (0,0) one edge after release; hsync = vsync = 1.
- Run one line, sample on p_tick → pixel_x 0..799 then 0; pixel_y steps 0→1 at the wrap; video_on falls at pixel_x = 640 and rises at 0; hsync low exactly for pixel_x 656..751 (96 ticks).
- Run a full frame → vsync low only for pixel_y 490..491 (1600 pixel ticks); frame_tick high exactly once, at (799,524), with the following tick at (0,0); frame_tick spacing 1,680,000 clks over 3 frames.
- Assert rst for 1 clk at pixel (300,200) → next cycle all outputs at reset values; timing restarts identically to power-up.
- CLK_DIV = 1, SYNC_POL = 1 → p_tick constant 1; hsync/vsync idle 0 and pulse 1 for 96 ticks and 2 lines respectively; line length 800 clks.
- Reduced parameters (H = 4/1/2/1, V = 3/1/1/1, CLK_DIV = 2) → exhaustive check of counter sequence, video_on and sync windows against a reference model for 5 frames.
